// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the ARM968E-S ID/EX control path: ALU commands,
// instruction classes, condition codes and data-processing opcodes.
package arm_ctrl_pkg;

    localparam logic [3:0] CMD_NOP = 4'b0000;
    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MVN = 4'b1001;

    typedef enum logic [1:0] {
        MODE_DP  = 2'b00,
        MODE_MEM = 2'b01,
        MODE_BR  = 2'b10,
        MODE_RSV = 2'b11
    } mode_e;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;

    typedef struct packed {
        logic       valid;
        logic [3:0] cmd;
        logic       wb_en;
        logic       mem_r_en;
        logic       mem_w_en;
        logic       b_en;
        logic       s_en;
    } ctrl_t;

endpackage

// File: rtl/arm_ctrl_pipe_if.sv
// ID-stage instruction fields in, registered ID/EX control word out.
interface arm_ctrl_pipe_if #(
    parameter int unsigned EXE_CMD_W = 4
);
    logic                 in_valid;
    logic [3:0]           cond;
    logic [3:0]           op_code;
    logic [1:0]           mode;
    logic                 s_in;
    logic                 i_in;
    logic [3:0]           sr_nzcv;
    logic                 stall;
    logic                 flush;
    logic                 out_valid;
    logic [EXE_CMD_W-1:0] exe_cmd;
    logic                 wb_en;
    logic                 mem_r_en;
    logic                 mem_w_en;
    logic                 b_en;
    logic                 s_en;
    logic                 shadow_busy;

    modport master (
        output in_valid, cond, op_code, mode, s_in, i_in, sr_nzcv, stall, flush,
        input  out_valid, exe_cmd, wb_en, mem_r_en, mem_w_en, b_en, s_en, shadow_busy
    );

    modport slave (
        input  in_valid, cond, op_code, mode, s_in, i_in, sr_nzcv, stall, flush,
        output out_valid, exe_cmd, wb_en, mem_r_en, mem_w_en, b_en, s_en, shadow_busy
    );
endinterface

// File: rtl/arm_cond_check.sv
// ARM condition-field evaluation against {N,Z,C,V}; shared with the execute stage.
module arm_cond_check
    import arm_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);
    logic n, z, c, v;

    always_comb begin
        {n, z, c, v} = nzcv;
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end
endmodule

// File: rtl/arm_ctrl_pipe.sv
// Registered ID-stage control unit: decode, condition gating, stall/flush
// handling and branch-shadow squashing into the ID/EX control register.
module arm_ctrl_pipe
    import arm_ctrl_pkg::*;
#(
    parameter int unsigned EXE_CMD_W = 4,
    parameter int unsigned BR_SHADOW = 1
) (
    input logic            clk,
    input logic            rst,
    arm_ctrl_pipe_if.slave bus
);
    localparam logic [2:0] SHADOW_LOAD = 3'(BR_SHADOW);

    ctrl_t      dec;
    ctrl_t      ctrl_d, ctrl_q;
    logic [2:0] shadow_d, shadow_q;
    logic       cond_pass;

    arm_cond_check u_cond (
        .cond (bus.cond),
        .nzcv (bus.sr_nzcv),
        .pass (cond_pass)
    );

    always_comb begin
        dec = '0;
        case (bus.mode)
            MODE_DP: begin
                dec.valid = 1'b1;
                dec.wb_en = 1'b1;
                dec.s_en  = bus.s_in;
                case (bus.op_code)
                    OP_MOV:  dec.cmd = CMD_MOV;
                    OP_MVN:  dec.cmd = CMD_MVN;
                    OP_ADD:  dec.cmd = CMD_ADD;
                    OP_ADC:  dec.cmd = CMD_ADC;
                    OP_SUB:  dec.cmd = CMD_SUB;
                    OP_SBC:  dec.cmd = CMD_SBC;
                    OP_AND:  dec.cmd = CMD_AND;
                    OP_ORR:  dec.cmd = CMD_ORR;
                    OP_EOR:  dec.cmd = CMD_EOR;
                    OP_CMP: begin
                        dec.cmd   = CMD_SUB;
                        dec.wb_en = 1'b0;
                        dec.s_en  = 1'b1;
                    end
                    OP_TST: begin
                        dec.cmd   = CMD_AND;
                        dec.wb_en = 1'b0;
                        dec.s_en  = 1'b1;
                    end
                    default: dec = '0;
                endcase
            end
            MODE_MEM: begin
                if (bus.op_code == OP_ADD) begin
                    dec.valid    = 1'b1;
                    dec.cmd      = CMD_ADD;
                    dec.wb_en    = bus.s_in;
                    dec.mem_r_en = bus.s_in;
                    dec.mem_w_en = !bus.s_in;
                end
            end
            MODE_BR: begin
                dec.valid = bus.i_in;
                dec.b_en  = bus.i_in;
                dec.cmd   = CMD_NOP;
            end
            default: dec = '0;
        endcase
    end

    // Flush beats stall beats accept; an idle (in_valid=0) cycle still
    // registers a bubble but leaves the shadow count untouched.
    always_comb begin
        ctrl_d   = ctrl_q;
        shadow_d = shadow_q;
        if (bus.flush) begin
            ctrl_d   = '0;
            shadow_d = '0;
        end else if (!bus.stall) begin
            ctrl_d = '0;
            if (bus.in_valid) begin
                if (shadow_q != '0) begin
                    shadow_d = shadow_q - 3'd1;
                end else if (cond_pass) begin
                    ctrl_d = dec;
                    if (dec.b_en) shadow_d = SHADOW_LOAD;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q   <= '0;
            shadow_q <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            shadow_q <= shadow_d;
        end
    end

    assign bus.out_valid   = ctrl_q.valid;
    assign bus.exe_cmd     = EXE_CMD_W'(ctrl_q.cmd);
    assign bus.wb_en       = ctrl_q.wb_en;
    assign bus.mem_r_en    = ctrl_q.mem_r_en;
    assign bus.mem_w_en    = ctrl_q.mem_w_en;
    assign bus.b_en        = ctrl_q.b_en;
    assign bus.s_en        = ctrl_q.s_en;
    assign bus.shadow_busy = (shadow_q != '0);

endmodule

// File: tb/tb_arm_ctrl_pipe.sv
// Directed and randomized checks of arm_ctrl_pipe against a table-driven reference model.
module tb_arm_ctrl_pipe;
    localparam int W  = 6;
    localparam int SH = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    arm_ctrl_pipe_if #(.EXE_CMD_W(W)) bus ();

    arm_ctrl_pipe #(.EXE_CMD_W(W), .BR_SHADOW(SH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    // reference state
    int e_v, e_cmd, e_wb, e_mr, e_mw, e_b, e_s;
    int cnt;

    // ALU command per data-processing opcode, -1 = illegal
    int dp_cmd [16] = '{6, 8, 4, -1, 2, 3, 5, -1, 6, -1, 4, -1, 7, 1, -1, 9};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack(input logic v, input logic [W-1:0] c, input logic wb,
                                         input logic mr, input logic mw, input logic b,
                                         input logic s, input logic busy);
        return 32'({v, c, wb, mr, mw, b, s, busy});
    endfunction

    function automatic logic [31:0] obs_vec();
        return pack(bus.out_valid, bus.exe_cmd, bus.wb_en, bus.mem_r_en, bus.mem_w_en,
                    bus.b_en, bus.s_en, bus.shadow_busy);
    endfunction

    function automatic logic [31:0] exp_vec();
        return pack(e_v != 0, W'(e_cmd), e_wb != 0, e_mr != 0, e_mw != 0, e_b != 0,
                    e_s != 0, cnt != 0);
    endfunction

    // ARM evaluates cond[3:1] and inverts on cond[0]; NV falls out as inverted AL.
    function automatic bit ref_cond(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c >> 1)
            0: base = z;
            1: base = cy;
            2: base = n;
            3: base = v;
            4: base = cy && !z;
            5: base = (n == v);
            6: base = !z && (n == v);
            default: base = 1;
        endcase
        return base ^ c[0];
    endfunction

    task automatic set_bubble();
        e_v = 0; e_cmd = 0; e_wb = 0; e_mr = 0; e_mw = 0; e_b = 0; e_s = 0;
    endtask

    task automatic ref_load();
        int op, m;
        op = int'(bus.op_code);
        m  = int'(bus.mode);
        set_bubble();
        if (!ref_cond(bus.cond, bus.sr_nzcv)) return;
        if (m == 0 && dp_cmd[op] >= 0) begin
            e_v = 1; e_cmd = dp_cmd[op];
            e_wb = (op == 8 || op == 10) ? 0 : 1;
            e_s  = (op == 8 || op == 10) ? 1 : int'(bus.s_in);
        end else if (m == 1 && op == 4) begin
            e_v = 1; e_cmd = 2;
            e_wb = int'(bus.s_in); e_mr = int'(bus.s_in); e_mw = 1 - int'(bus.s_in);
        end else if (m == 2 && bus.i_in) begin
            e_v = 1; e_b = 1;
            cnt = SH;
        end
    endtask

    task automatic model_tick();
        if (bus.flush) begin
            set_bubble();
            cnt = 0;
        end else if (bus.stall) begin
            // hold
        end else if (!bus.in_valid) begin
            set_bubble();
        end else if (cnt > 0) begin
            set_bubble();
            cnt--;
        end else begin
            ref_load();
        end
    endtask

    task automatic drive(input bit v, input logic [3:0] c, input logic [3:0] op,
                         input logic [1:0] m, input bit s, input bit i,
                         input logic [3:0] f, input bit st, input bit fl);
        bus.in_valid = v; bus.cond = c; bus.op_code = op; bus.mode = m;
        bus.s_in = s; bus.i_in = i; bus.sr_nzcv = f; bus.stall = st; bus.flush = fl;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_tick();
        @(negedge clk);
        check_eq(tag, obs_vec(), exp_vec());
    endtask

    task automatic add_i();
        drive(1, 4'hE, 4'b0100, 2'b00, 1, 0, 4'h0, 0, 0);
    endtask

    task automatic br_i();
        drive(1, 4'hE, 4'h0, 2'b10, 0, 1, 4'h0, 0, 0);
    endtask

    initial begin
        drive(0, 4'h0, 4'h0, 2'b00, 0, 0, 4'h0, 0, 0);
        set_bubble(); cnt = 0;
        repeat (3) @(negedge clk);
        check_eq("reset_hold", obs_vec(), 32'd0);
        rst = 1'b1;
        step("idle");

        add_i(); step("add");
        check_eq("add_cmd", 32'(bus.exe_cmd), 32'd2);
        drive(1, 4'hE, 4'b1010, 2'b00, 0, 0, 4'h0, 0, 0); step("cmp");

        drive(1, 4'h0, 4'b0010, 2'b00, 0, 0, 4'b0100, 0, 0); step("sub_eq_pass");
        drive(1, 4'h0, 4'b0010, 2'b00, 0, 0, 4'b0000, 0, 0); step("sub_eq_fail");
        drive(1, 4'hF, 4'b0010, 2'b00, 0, 0, 4'b0100, 0, 0); step("sub_nv");
        drive(1, 4'hE, 4'b0011, 2'b00, 1, 0, 4'b0000, 0, 0); step("dp_illegal");

        drive(1, 4'hE, 4'b0100, 2'b01, 1, 0, 4'h0, 0, 0); step("ldr");
        drive(1, 4'hE, 4'b0100, 2'b01, 0, 0, 4'h0, 0, 0); step("str");
        drive(1, 4'hE, 4'b0101, 2'b01, 1, 0, 4'h0, 0, 0); step("mem_illegal");

        br_i(); step("branch");
        check_eq("branch_busy", 32'(bus.shadow_busy), 32'd1);
        add_i(); step("shadow1");
        step("shadow2");
        step("after_shadow");
        check_eq("after_shadow_valid", 32'(bus.out_valid), 32'd1);

        br_i(); step("branch2");
        add_i(); step("shadow2_1");
        drive(0, 4'hE, 4'b0100, 2'b00, 1, 0, 4'h0, 0, 0); step("shadow_idle");
        add_i(); step("shadow2_2");
        step("after_shadow2");

        drive(1, 4'hE, 4'b1101, 2'b00, 0, 0, 4'h0, 0, 0); step("mov");
        add_i(); bus.stall = 1;
        repeat (3) step("stall_hold");
        check_eq("stall_cmd", 32'(bus.exe_cmd), 32'd1);
        bus.stall = 0; step("stall_release");
        br_i(); step("branch3");
        add_i(); bus.stall = 1; bus.flush = 1; step("stall_flush");
        check_eq("flush_busy", 32'(bus.shadow_busy), 32'd0);

        bus.stall = 0; bus.flush = 0; step("pre_reset");
        #2 rst = 1'b0;
        #1 set_bubble(); cnt = 0;
        check_eq("async_reset", obs_vec(), 32'd0);
        bus.stall = 1;
        @(negedge clk);
        rst = 1'b1;
        step("reset_mid_stall");
        bus.stall = 0;

        for (int k = 0; k < 3000; k++) begin
            logic [1:0] m;
            logic [3:0] op;
            m  = 2'($urandom_range(0, 3));
            op = 4'($urandom);
            if (m == 2'b01 && $urandom_range(0, 3) != 0) op = 4'b0100;
            drive($urandom_range(0, 7) != 0,
                  ($urandom_range(0, 1) != 0) ? 4'hE : 4'($urandom),
                  op, m, 1'($urandom), 1'($urandom), 4'($urandom),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
            step("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/arm_ctrl_pipe.md
Name: arm_ctrl_pipe

Overview:
- Registered ID-stage control unit for the ARM968E-S core.
- Decodes op_code/mode/s/i into EXE command and control enables, and gates the result by the ARM condition field against the current NZCV flags.
- Registers the result into the ID/EX control register.
- Adds what a purely combinational decoder lacks: valid tracking, stall hold, flush bubbles, parametrised command width, and automatic squashing of a configurable number of branch-shadow instructions.

Parameters:
- EXE_CMD_W, 4: width of exe_cmd. Must be >= 4; encodings are zero-extended.
- BR_SHADOW, 1: number of accepted instructions squashed after a branch issues. Range 0..7.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  ID holds a real instruction.
- cond  in  4  instruction bits 31:28.
- op_code  in  4  data-processing opcode.
- mode  in  2  instruction class (00 data, 01 memory, 10 branch).
- s_in  in  1  S bit; L bit for mode 01.
- i_in  in  1  I bit; for mode 10, set means branch.
- sr_nzcv  in  4  status register {N,Z,C,V}.
- stall  in  1  hazard unit: hold ID/EX, do not consume input.
- flush  in  1  branch taken in EX: kill ID/EX contents.
- out_valid  out  1  ID/EX holds a live instruction.
- exe_cmd  out  EXE_CMD_W  ALU command.
- wb_en  out  1  register write-back enable.
- mem_r_en  out  1  memory read enable.
- mem_w_en  out  1  memory write enable.
- b_en  out  1  branch.
- s_en  out  1  update status register.
- shadow_busy  out  1  shadow counter nonzero.

Behaviour:
- Reset (rst=0, async): all outputs 0, exe_cmd 0, shadow counter 0.
- Latency: 1 cycle, input to registered outputs.
- Bubble: out_valid=0, exe_cmd=0, all enables 0.
- Decode, mode 00:
  - 1101 MOV 0001; 1111 MVN 1001; 0100 ADD 0010; 0101 ADC 0011; 0010 SUB 0100; 0110 SBC 0101.
  - 0000 AND 0110; 1100 ORR 0111; 0001 EOR 1000; 1010 CMP 0100; 1000 TST 0110.
  - wb_en=1 except CMP/TST. s_en=s_in, forced 1 for CMP/TST.
  - Any other opcode → bubble.
- Decode, mode 01 with op_code 0100:
  - s_in=1 → LDR: exe_cmd 0010, wb_en=1, mem_r_en=1.
  - s_in=0 → STR: exe_cmd 0010, mem_w_en=1.
  - Other op_code → bubble.
- Decode, mode 10: i_in=1 → b_en=1, exe_cmd 0, no other enables; i_in=0 → bubble.
- Decode, mode 11: bubble.
- Condition check against sr_nzcv, standard ARM codes:
  - 0000 EQ … 1101 LE; 1110 AL passes; 1111 never passes.
  - Fail → bubble.
- Accept: in_valid && !stall && !flush. On accept the register loads the decoded result, or a bubble if in_valid=0, the condition fails, or the counter is nonzero.
- Shadow counter (3 bits):
  - Loads BR_SHADOW when an accepted, unsquashed branch is registered.
  - Decrements on each accept while nonzero; that instruction is squashed.
  - Cycles with in_valid=0 do not decrement.
  - BR_SHADOW=0: the counter never becomes nonzero.
- stall=1, flush=0: all outputs and the counter hold.
- flush=1: register becomes a bubble and the counter clears. Flush has priority over stall and accept.
- A reset deasserting mid-stall starts from the bubble state.

Decomposition:
- Shared package arm_ctrl_pkg holds:
  - EXE_CMD localparams (CMD_MOV … CMD_EOR).
  - Mode encodings (MODE_DP, MODE_MEM, MODE_BR).
  - Condition-code localparams (COND_EQ … COND_NV).
  - Opcode localparams.
- One combinational sub-module, arm_cond_check (cond, nzcv → pass), reused later by the execute stage.
- The decoder and pipeline register stay in the top module.

Test Plan:
- Reset asserted mid-stream with outputs live → all outputs 0 immediately, before the next clk edge.
- ADD (mode 00, op 0100, s_in=1, cond 1110) → next cycle out_valid=1, exe_cmd=0010, wb_en=1, s_en=1. CMP (op 1010, s_in=0) → exe_cmd=0100, wb_en=0, s_en=1.
- Condition gating: SUB with cond 0000 (EQ), sr_nzcv=0100 → executes; same with sr_nzcv=0000 → bubble. cond 1111 → always bubble.
- LDR then STR (mode 01, op 0100, s_in 1/0) → mem_r_en=1 with wb_en=1, then mem_w_en=1 with wb_en=0, both exe_cmd=0010.
- BR_SHADOW=2: branch followed by 3 ADDs → b_en=1, shadow_busy=1, two bubbles, third ADD valid.
  - Variant with in_valid=0 for one cycle inside the shadow → still exactly two ADDs squashed.
- stall=1 for 3 cycles with MOV registered → outputs hold MOV, input not consumed. stall=1 with flush=1 → bubble next cycle and shadow_busy=0.
